dmem_handshake_resp: RTL and testbench

- Data-memory responder for a load/store requester using a req/ready handshake with programmable wait states.
- Replaces the zero-latency combinational data memory so the datapath can be verified against realistic memory timing.
- Supports byte-strobed writes and flags misaligned or out-of-range accesses.
- Sits on the DataAdr/WriteData/MemWrite side of the core, answering one transaction at a time.

---
 rtl/dmem_handshake_resp_if.sv | 24 ++
 rtl/dmem_handshake_resp.sv | 143 ++++++++++++++
 tb/tb_dmem_handshake_resp.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_handshake_resp_if.sv
// Request/response bundle between a load/store requester and the data-memory
// responder. The master drives the request side and the slave drives the
// response side.
interface dmem_handshake_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/dmem_handshake_resp.sv
// Data-memory responder with a req/ready handshake and programmable wait states.
// Each transaction is accepted in IDLE. It then spends LATENCY cycles in WAIT
// and one cycle in RESP, where ready pulses high. Stores commit byte-wise on the
// edge that leaves RESP. Misaligned or out-of-range accesses respond with err=1
// and leave memory untouched. All outputs come straight from registers.
module dmem_handshake_resp #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_handshake_resp_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // Transaction fields captured at accept and used until the response completes.
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [3:0]  r_cnt;

  logic        r_ready;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_busy;

  logic [31:0] r_mem [DEPTH];

  // With LATENCY=0 the response is decided on the accept edge itself, before
  // the captured copies exist. Select the live bus in that case.
  logic          w_src_we;
  logic [31:0]   w_src_addr;
  logic          w_src_bad;
  logic [AW-1:0] w_src_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_enter_resp;
  logic          w_ready_nxt;
  logic          w_err_nxt;
  logic [31:0]   w_rdata_nxt;
  logic          w_busy_nxt;

  assign w_src_we   = (r_state == S_IDLE) ? bus.we   : r_we;
  assign w_src_addr = (r_state == S_IDLE) ? bus.addr : r_addr;
  assign w_src_bad  = (w_src_addr[1:0] != 2'b00) ||
                      ({2'b00, w_src_addr[31:2]} >= 32'(DEPTH));
  assign w_src_idx  = w_src_addr[2 +: AW];
  assign w_wr_idx   = r_addr[2 +: AW];

  // State register: synchronous reset aborts any transaction in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> WAIT/RESP on req, WAIT counts down, RESP -> IDLE.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; an incomplete assignment would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (bus.req) w_next_state = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: next values for the registered response outputs.
  always_comb begin
    w_enter_resp = (w_next_state == S_RESP);
    w_ready_nxt  = w_enter_resp;
    w_err_nxt    = w_enter_resp && w_src_bad;
    w_rdata_nxt  = r_rdata;
    if (w_enter_resp) begin
      w_rdata_nxt = (w_src_we || w_src_bad) ? 32'd0 : r_mem[w_src_idx];
    end
    w_busy_nxt = (w_next_state != S_IDLE);
  end

  // Output registers: ready/err pulse only in RESP; rdata holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Capture the request at accept and run the wait-state counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_cnt   <= 4'd0;
    end else if (r_state == S_IDLE && bus.req) begin
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_be    <= bus.be;
      r_cnt   <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Store commit on the edge leaving RESP, one byte lane per captured enable.
  // NOTE: the storage array is deliberately not reset; contents survive reset
  // and a reset flop per bit would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_RESP && r_we && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_dmem_handshake_resp.sv
// Self-checking bench for dmem_handshake_resp. Two responders are instantiated.
// dut_a uses LATENCY=2 and dut_b uses LATENCY=0. A behavioural word-array model
// predicts err/rdata/latency for every transaction.
module tb_dmem_handshake_resp;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_handshake_resp_if if_a ();
  dmem_handshake_resp_if if_b ();

  dmem_handshake_resp #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  dmem_handshake_resp #(.DEPTH(DEPTH), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  typedef struct packed {
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] rdata;
  } obs_t;

  int vectors     = 0;
  int miscompares = 0;

  // Expected memory image per responder (index 0 = dut_a, 1 = dut_b).
  logic [31:0] mdl [2][DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    if (sel) begin
      if_b.req = req; if_b.we = we; if_b.addr = addr; if_b.wdata = wdata; if_b.be = be;
    end else begin
      if_a.req = req; if_a.we = we; if_a.addr = addr; if_a.wdata = wdata; if_a.be = be;
    end
  endtask

  function automatic obs_t sample(input bit sel);
    if (sel) return {if_b.ready, if_b.err, if_b.busy, if_b.rdata};
    return {if_a.ready, if_a.err, if_a.busy, if_a.rdata};
  endfunction

  // Reference behaviour: reject misaligned/out-of-range, otherwise store by byte
  // lanes or return the whole word.
  task automatic model(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic e, output logic [31:0] rd);
    int idx;
    e  = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    rd = 32'd0;
    if (!e) begin
      idx = int'(addr / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[sel][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = mdl[sel][idx];
      end
    end
  endtask

  // One full transaction with req held until ready. The optional scramble
  // changes every request field after the accept edge.
  task automatic run(input bit sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input bit scramble, input string tag);
    logic        exp_e;
    logic [31:0] exp_rd;
    obs_t        o;
    obs_t        resp;
    int          n;
    bit          got;
    model(sel, we, addr, wdata, be, exp_e, exp_rd);
    resp = '0;
    drive(sel, 1'b1, we, addr, wdata, be);
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      o = sample(sel);
      if (n == 1) begin
        check({tag, ".busy_acc"}, 32'(o.busy), 32'd1);
        if (scramble) drive(sel, 1'b1, ~we, addr + 32'd4, ~wdata, 4'hF);
      end
      if (o.ready) begin
        got  = 1'b1;
        resp = o;
      end
    end
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check({tag, ".lat"}, 32'(n), sel ? 32'd1 : 32'd3);
    check({tag, ".err"}, 32'(resp.err), 32'(exp_e));
    check({tag, ".rdata"}, resp.rdata, exp_rd);
    @(posedge clk); #1;
    o = sample(sel);
    check({tag, ".busy_end"}, 32'(o.busy), 32'd0);
    check({tag, ".ready_end"}, 32'(o.ready), 32'd0);
  endtask

  initial begin
    obs_t        o;
    int          rdy_cnt;
    int          k;
    logic [31:0] a;
    logic [31:0] rs_addrs [3];

    // Reset state on both responders.
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      o = sample(s[0]);
      check("rst.ready", 32'(o.ready), 32'd0);
      check("rst.err",   32'(o.err),   32'd0);
      check("rst.busy",  32'(o.busy),  32'd0);
      check("rst.rdata", o.rdata,      32'd0);
    end

    // Give every word a known value so later loads are fully defined.
    for (int i = 0; i < DEPTH; i++) begin
      run(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "init_a");
      run(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "init_b");
    end

    // 1: basic store/load with two wait states.
    run(1'b0, 1'b1, 32'd100, 32'h0000_0019, 4'hF, 1'b0, "t1.st");
    run(1'b0, 1'b0, 32'd100, 32'd0,         4'hF, 1'b0, "t1.ld");
    check("t1.model", mdl[0][25], 32'h0000_0019);

    // 2: byte strobes, including the all-disabled store.
    run(1'b0, 1'b1, 32'd96, 32'hAABB_CCDD, 4'hF,    1'b0, "t2.st_full");
    run(1'b0, 1'b1, 32'd96, 32'h1122_3344, 4'b0010, 1'b0, "t2.st_byte1");
    run(1'b0, 1'b0, 32'd96, 32'd0,         4'h0,    1'b0, "t2.ld");
    run(1'b0, 1'b1, 32'd96, 32'h5566_7788, 4'h0,    1'b0, "t2.st_none");
    run(1'b0, 1'b0, 32'd96, 32'd0,         4'hF,    1'b0, "t2.ld_after");
    check("t2.model", mdl[0][24], 32'hAABB_33DD);

    // 3: misaligned and out-of-range accesses.
    run(1'b0, 1'b0, 32'h62,  32'd0,         4'hF, 1'b0, "t3.ld_mis");
    run(1'b0, 1'b1, 32'h62,  32'hFFFF_FFFF, 4'hF, 1'b0, "t3.st_mis");
    run(1'b0, 1'b0, 32'd256, 32'd0,         4'hF, 1'b0, "t3.ld_oor");
    run(1'b0, 1'b1, 32'd256, 32'hFFFF_FFFF, 4'hF, 1'b0, "t3.st_oor");
    run(1'b0, 1'b0, 32'd96,  32'd0,         4'hF, 1'b0, "t3.reload");

    // 4: reset during WAIT aborts a store without committing it.
    drive(1'b0, 1'b1, 1'b1, 32'd100, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    o = sample(1'b0);
    check("t4.busy_acc", 32'(o.busy), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    o = sample(1'b0);
    check("t4.busy_rst", 32'(o.busy), 32'd0);
    rdy_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sample(1'b0).ready) rdy_cnt++;
    end
    check("t4.no_ready", 32'(rdy_cnt), 32'd0);
    run(1'b0, 1'b0, 32'd100, 32'd0, 4'hF, 1'b0, "t4.ld");

    // 5: LATENCY=0 with req held continuously across three loads.
    run(1'b1, 1'b1, 32'd0, 32'hC0DE_0000, 4'hF, 1'b0, "t5.st0");
    run(1'b1, 1'b1, 32'd4, 32'hC0DE_0004, 4'hF, 1'b0, "t5.st1");
    run(1'b1, 1'b1, 32'd8, 32'hC0DE_0008, 4'hF, 1'b0, "t5.st2");
    rs_addrs[0] = 32'd0;
    rs_addrs[1] = 32'd4;
    rs_addrs[2] = 32'd8;
    k = 0;
    drive(1'b1, 1'b1, 1'b0, rs_addrs[0], 32'd0, 4'hF);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      o = sample(1'b1);
      if (c <= 6) check("t5.ready_pattern", 32'(o.ready), 32'(c % 2));
      else        check("t5.no_extra", 32'(o.ready), 32'd0);
      if (o.ready && k < 3) begin
        check("t5.rdata", o.rdata, mdl[1][rs_addrs[k] / 4]);
        k++;
        if (k < 3) drive(1'b1, 1'b1, 1'b0, rs_addrs[k], 32'd0, 4'hF);
        else       drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end
    end
    check("t5.count", 32'(k), 32'd3);

    // 6: request fields changed while busy have no effect.
    run(1'b0, 1'b1, 32'd4, 32'h0BAD_F00D, 4'hF, 1'b0, "t6.st");
    run(1'b0, 1'b0, 32'd4, 32'h1234_5678, 4'hF, 1'b1, "t6.ld_scr");
    run(1'b0, 1'b0, 32'd8, 32'd0, 4'hF, 1'b0, "t6.ld8");
    run(1'b0, 1'b0, 32'd4, 32'd0, 4'hF, 1'b0, "t6.ld4");

    // Randomized traffic on both responders.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        2:       a = 32'(DEPTH * 4) + ($urandom % 32'h1000);
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      run(i[0], 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
